// File: rtl/mips_avalon_mem_slave.sv
// Avalon-MM word RAM slave for mips_cpu_bus: programmable wait states, byte-lane writes,
// a back-door preload port and sticky decode/protocol error flags.
module mips_avalon_mem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err_range,
    output logic        err_proto,
    output logic [31:0] err_addr
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wait_d;

    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_write;

    logic        accept;
    logic        acc_go, acc_write, acc_hit;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_be;
    logic [AW-1:0] acc_idx, load_idx;
    logic        load_hit;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE_ADDR) && (a < END_ADDR);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    assign accept = (state_q == IDLE) && (read || write);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = waitrequest;
        acc_go    = 1'b0;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        acc_write = lat_write;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        acc_go    = 1'b1;
                        acc_addr  = address;
                        acc_wdata = writedata;
                        acc_be    = byteenable;
                        acc_write = write;
                    end else begin
                        // DONE counts as the last wait cycle, so waitrequest is high WAIT_CYCLES cycles.
                        state_d = (WAIT_CYCLES == 1) ? DONE : BUSY;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        wait_d  = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = DONE;
            end
            DONE: begin
                acc_go  = 1'b1;
                wait_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_hit  = in_window(acc_addr);
    assign acc_idx  = word_idx(acc_addr);
    assign load_hit = load_en && in_window(load_addr);
    assign load_idx = word_idx(load_addr);

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            waitrequest <= 1'b0;
            readdata    <= 32'h0;
            err_range   <= 1'b0;
            err_proto   <= 1'b0;
            err_addr    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            waitrequest <= wait_d;
            if (accept && read && write) err_proto <= 1'b1;
            if (acc_go) begin
                if (!acc_hit) begin
                    err_range <= 1'b1;
                    if (!err_range) err_addr <= acc_addr;
                    if (!acc_write) readdata <= 32'h0;
                end else if (!acc_write) begin
                    readdata <= mem[acc_idx];
                end
            end
        end
    end

    // NOTE: the request latch and the RAM carry no reset; only control state needs a known value.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= address;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            lat_write <= write;
        end
    end

    // The bus write is issued after the load, so on a shared word its enabled lanes win.
    always_ff @(posedge clk) begin
        if (load_hit) mem[load_idx] <= load_data;
        if (reset && acc_go && acc_hit && acc_write) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_be[n]) mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mips_avalon_mem_slave.sv
// Scoreboard bench for mips_avalon_mem_slave: three instances (0, 3 and 2 wait states) share one clock.
module tb_mips_avalon_mem_slave;

    localparam int NI = 3;
    localparam int WAITS [NI] = '{0, 3, 2};

    logic        clk = 1'b0;
    logic        reset      [NI];
    logic [31:0] address    [NI];
    logic        read       [NI];
    logic        write      [NI];
    logic [31:0] writedata  [NI];
    logic [3:0]  byteenable [NI];
    logic        waitrequest[NI];
    logic [31:0] readdata   [NI];
    logic        load_en    [NI];
    logic [31:0] load_addr  [NI];
    logic [31:0] load_data  [NI];
    logic        err_range  [NI];
    logic        err_proto  [NI];
    logic [31:0] err_addr   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mips_avalon_mem_slave #(.WAIT_CYCLES(WAITS[g])) u_dut (
            .clk(clk), .reset(reset[g]), .address(address[g]), .read(read[g]),
            .write(write[g]), .writedata(writedata[g]), .byteenable(byteenable[g]),
            .waitrequest(waitrequest[g]), .readdata(readdata[g]), .load_en(load_en[g]),
            .load_addr(load_addr[g]), .load_data(load_data[g]), .err_range(err_range[g]),
            .err_proto(err_proto[g]), .err_addr(err_addr[g])
        );
    end

    typedef struct {
        int          inst;
        logic [31:0] exp;
        string       nm;
    } sb_t;

    sb_t  sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic req_s [NI];
    logic wb_s  [NI];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a completion is a sampled request on the zero-wait slave or a falling waitrequest.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                req_s[i] = reset[i] && (read[i] || write[i]);
                wb_s[i]  = waitrequest[i];
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                if ((WAITS[i] == 0 && req_s[i]) || (wb_s[i] === 1'b1 && waitrequest[i] === 1'b0)) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_completion: inst %0d readdata %h, nothing expected", i, readdata[i]);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("%s_inst", e.nm), i, e.inst);
                        check(e.nm, readdata[i], e.exp);
                    end
                end
            end
        end
    end

    task automatic idle_inputs(input int i);
        read[i] = 1'b0; write[i] = 1'b0; load_en[i] = 1'b0;
        address[i] = 32'h0; writedata[i] = 32'h0; byteenable[i] = 4'h0;
        load_addr[i] = 32'h0; load_data[i] = 32'h0;
    endtask

    task automatic backdoor(input int i, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en[i] = 1'b1; load_addr[i] = a; load_data[i] = d;
        @(negedge clk);
        load_en[i] = 1'b0;
    endtask

    // Holds the request while waitrequest is high, optionally moving the address meanwhile.
    task automatic bus(input int i, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp,
                       input string nm, input logic [31:0] busy_addr, output int wcnt);
        @(negedge clk);
        read[i] = rd; write[i] = wr; address[i] = a; writedata[i] = d; byteenable[i] = be;
        sb.push_back('{inst: i, exp: exp, nm: nm});
        wcnt = 0;
        @(negedge clk);
        while (waitrequest[i] === 1'b1 && wcnt < 40) begin
            wcnt++;
            address[i] = busy_addr;
            @(negedge clk);
        end
        if (wcnt >= 40) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: waitrequest still high after %0d cycles, required low", nm, wcnt);
        end
        read[i] = 1'b0; write[i] = 1'b0;
    endtask

    initial begin
        int wc;
        for (int i = 0; i < NI; i++) begin
            reset[i] = 1'b0;
            idle_inputs(i);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_wait%0d", i), waitrequest[i], 0);
            check($sformatf("rst_rdata%0d", i), readdata[i], 0);
            check($sformatf("rst_errs%0d", i), {err_range[i], err_proto[i]}, 0);
            check($sformatf("rst_eaddr%0d", i), err_addr[i], 0);
            reset[i] = 1'b1;
        end

        // Zero-wait instance: preload, single-cycle read, hold.
        backdoor(0, 32'hBFC00000, 32'h24020005);
        bus(0, 1, 0, 32'hBFC00000, 0, 4'h0, 32'h24020005, "t1_read", 32'hBFC00000, wc);
        check("t1_wait_cycles", wc, 0);
        repeat (3) @(negedge clk);
        check("t1_hold", readdata[0], 32'h24020005);

        // Lane writes; readdata must stay untouched by writes.
        bus(0, 0, 1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, 32'h24020005, "t2_w_full", 32'hBFC00010, wc);
        bus(0, 0, 1, 32'hBFC00010, 32'h000000AA, 4'h1, 32'h24020005, "t2_w_lane0", 32'hBFC00010, wc);
        bus(0, 1, 0, 32'hBFC00010, 0, 4'h0, 32'hDEADBEAA, "t2_r1", 32'hBFC00010, wc);
        bus(0, 0, 1, 32'hBFC00010, 32'h12340000, 4'hC, 32'hDEADBEAA, "t2_w_hi", 32'hBFC00010, wc);
        bus(0, 1, 0, 32'hBFC00010, 0, 4'h0, 32'h1234BEAA, "t2_r2", 32'hBFC00010, wc);
        bus(0, 0, 1, 32'hBFC00010, 32'hFFFFFFFF, 4'h0, 32'h1234BEAA, "be0_w", 32'hBFC00010, wc);
        bus(0, 1, 0, 32'hBFC00010, 0, 4'h0, 32'h1234BEAA, "be0_r", 32'hBFC00010, wc);

        // Load and bus write to the same word at the same edge.
        @(negedge clk);
        write[0] = 1'b1; address[0] = 32'hBFC00020; writedata[0] = 32'h22222222; byteenable[0] = 4'b0101;
        load_en[0] = 1'b1; load_addr[0] = 32'hBFC00020; load_data[0] = 32'h11111111;
        sb.push_back('{inst: 0, exp: 32'h1234BEAA, nm: "coll_w"});
        @(negedge clk);
        idle_inputs(0);
        bus(0, 1, 0, 32'hBFC00020, 0, 4'h0, 32'h11221122, "coll_r", 32'hBFC00020, wc);

        // Read racing a load of the same word sees the old contents.
        @(negedge clk);
        read[0] = 1'b1; address[0] = 32'hBFC00020;
        load_en[0] = 1'b1; load_addr[0] = 32'hBFC00020; load_data[0] = 32'h33333333;
        sb.push_back('{inst: 0, exp: 32'h11221122, nm: "rdload_old"});
        @(negedge clk);
        idle_inputs(0);
        bus(0, 1, 0, 32'hBFC00020, 0, 4'h0, 32'h33333333, "rdload_new", 32'hBFC00020, wc);

        // Out-of-range load is silent; last word of the window is in range.
        backdoor(0, 32'h00000000, 32'hFFFFFFFF);
        bus(0, 0, 1, 32'hBFC00FFC, 32'hCAFEF00D, 4'hF, 32'h33333333, "last_w", 32'hBFC00FFC, wc);
        bus(0, 1, 0, 32'hBFC00FFC, 0, 4'h0, 32'hCAFEF00D, "last_r", 32'hBFC00FFC, wc);
        check("no_err_range", err_range[0], 0);
        check("no_err_proto", err_proto[0], 0);

        // Out-of-range reads.
        bus(0, 1, 0, 32'h00000000, 0, 4'h0, 32'h0, "oor_r_low", 32'h0, wc);
        check("oor_flag", err_range[0], 1);
        bus(0, 1, 0, 32'hBFC01000, 0, 4'h0, 32'h0, "oor_r_high", 32'hBFC01000, wc);
        check("oor_eaddr_first", err_addr[0], 32'h00000000);

        // read and write together: protocol error, executed as a write.
        bus(0, 1, 1, 32'hBFC00030, 32'h00000055, 4'hF, 32'h0, "proto_w", 32'hBFC00030, wc);
        check("proto_flag", err_proto[0], 1);
        bus(0, 1, 0, 32'hBFC00030, 0, 4'h0, 32'h00000055, "proto_r", 32'hBFC00030, wc);

        // Three wait states; address changes during BUSY are ignored.
        backdoor(1, 32'hBFC00040, 32'hA5A5A5A5);
        backdoor(1, 32'hBFC00000, 32'h0BADF00D);
        bus(1, 1, 0, 32'hBFC00040, 0, 4'h0, 32'hA5A5A5A5, "w3_r1", 32'hBFC00000, wc);
        check("w3_r1_cycles", wc, 3);
        bus(1, 0, 1, 32'hBFC00040, 32'h0000BEEF, 4'b0011, 32'hA5A5A5A5, "w3_w", 32'hBFC00000, wc);
        check("w3_w_cycles", wc, 3);
        bus(1, 1, 0, 32'hBFC00040, 0, 4'h0, 32'hA5A5BEEF, "w3_r2", 32'hBFC00040, wc);

        // Two wait states; reset during BUSY of a write aborts it.
        backdoor(2, 32'hBFC00050, 32'h76543210);
        bus(2, 1, 0, 32'hBFC00050, 0, 4'h0, 32'h76543210, "w2_r1", 32'hBFC00050, wc);
        check("w2_r1_cycles", wc, 2);
        @(negedge clk);
        write[2] = 1'b1; address[2] = 32'hBFC00050; writedata[2] = 32'hFFFFFFFF; byteenable[2] = 4'hF;
        sb.push_back('{inst: 2, exp: 32'h0, nm: "abort_rdata"});
        @(negedge clk);
        check("abort_busy", waitrequest[2], 1);
        reset[2] = 1'b0;
        idle_inputs(2);
        @(negedge clk);
        check("abort_wait", waitrequest[2], 0);
        reset[2] = 1'b1;
        bus(2, 1, 0, 32'hBFC00050, 0, 4'h0, 32'h76543210, "abort_mem", 32'hBFC00050, wc);
        check("abort_cycles", wc, 2);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
